// File: rtl/counter_run_ctrl_pkg.sv
// Shared definitions for the front-panel counter run controller; the state
// encoding is also consumed by the display logic.
package counter_run_ctrl_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } run_state_t;

endpackage

// File: rtl/counter_run_ctrl_if.sv
// Signal bundle between the run controller, its stimulus sources and the
// controlled counter. master drives ticks/keys/counter value; slave is the controller.
interface counter_run_ctrl_if
  import counter_run_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
);
  logic             tick;
  logic             key_start_n;
  logic             key_clr_n;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] limit;
  logic             cnt_en;
  logic             cnt_clr;
  run_state_t       state;
  logic             done;

  modport master (
    output tick, key_start_n, key_clr_n, cnt_val, limit,
    input  cnt_en, cnt_clr, state, done
  );

  modport slave (
    input  tick, key_start_n, key_clr_n, cnt_val, limit,
    output cnt_en, cnt_clr, state, done
  );
endinterface

// File: rtl/counter_run_ctrl_key_debounce.sv
// Raw active-low push-button conditioner: 2-flop synchronizer, stability
// counter and a one-cycle pulse on the accepted press (1->0) edge.
module key_debounce #(
  parameter int DB_CYC = 1_000_000,
  parameter int DB_W   = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

  logic            sync_p0;
  logic            sync_p1;
  logic            db_lvl;
  logic [DB_W-1:0] db_cnt;

  // stage p0/p1: metastability guard, released-key value out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

  // debounce stage: any sample matching the accepted level restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_lvl <= 1'b1;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_p1 == db_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        db_lvl <= sync_p1;
        press  <= ~sync_p1;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/counter_run_ctrl.sv
// Run/pause/clear sequencer producing gated count-enable and clear strobes.
// Optional periodic mode: define COUNTER_RUN_CTRL_AUTO_RELOAD_EN.
module counter_run_ctrl
  import counter_run_ctrl_pkg::*;
#(
  parameter int DB_CYC = 1_000_000,
  parameter int DB_W   = 20,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  counter_run_ctrl_if.slave     bus
);

  logic             start_evt;
  logic             clr_evt;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] limit;
  logic             limit_hit;

  run_state_t state_q;
  run_state_t state_nxt;
  logic       cnt_en_q;
  logic       cnt_en_nxt;
  logic       cnt_clr_q;
  logic       cnt_clr_nxt;
  logic       done_q;

  key_debounce #(.DB_CYC(DB_CYC), .DB_W(DB_W)) u_key_start (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (bus.key_start_n),
    .press (start_evt)
  );

  key_debounce #(.DB_CYC(DB_CYC), .DB_W(DB_W)) u_key_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (bus.key_clr_n),
    .press (clr_evt)
  );

  assign cnt_val = bus.cnt_val;
  assign limit   = bus.limit;

  // While a clear strobe is in flight the counter still shows its old value,
  // so the terminal compare is suppressed for that one cycle.
  assign limit_hit = (cnt_val == limit) && !cnt_clr_q;

  always_comb begin
    state_nxt   = state_q;
    cnt_en_nxt  = 1'b0;
    cnt_clr_nxt = 1'b0;
    if (clr_evt) begin
      state_nxt   = ST_IDLE;
      cnt_clr_nxt = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_evt) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (start_evt) begin
            state_nxt = ST_PAUSE;
          end else if (limit_hit) begin
            state_nxt = ST_DONE;
          end else if (bus.tick) begin
            cnt_en_nxt = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (start_evt) state_nxt = ST_RUN;
        end
        ST_DONE: begin
`ifdef COUNTER_RUN_CTRL_AUTO_RELOAD_EN
          if (bus.tick) begin
            state_nxt   = ST_RUN;
            cnt_clr_nxt = 1'b1;
          end
`endif
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // output stage: every strobe and status bit is registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_en_q  <= cnt_en_nxt;
      cnt_clr_q <= cnt_clr_nxt;
      done_q    <= (state_nxt == ST_DONE);
    end
  end

  assign bus.state   = state_q;
  assign bus.cnt_en  = cnt_en_q;
  assign bus.cnt_clr = cnt_clr_q;
  assign bus.done    = done_q;

endmodule

// File: doc/counter_run_ctrl.md
Name: counter_run_ctrl

Overview:
- Run/pause/clear sequencer for the front-panel counter datapath.
- Consumes the 1-cycle slow tick from the pulse generator and two raw push-buttons.
- Issues gated count-enable and clear strobes to the downstream counter.
- Stops the counter when it reaches a programmable limit.

Parameters:
- DB_CYC, 1_000_000, clock cycles a key must be stable before it is accepted (20 ms at 50 MHz).
- DB_W, 20, width of the debounce counter; must hold DB_CYC-1.
- CNT_W, 8, width of cnt_val and limit.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle enable pulse from the slow pulse generator.
- key_start_n  in  1  raw start/pause button, active-low, asynchronous.
- key_clr_n  in  1  raw clear button, active-low, asynchronous.
- cnt_val  in  CNT_W  current value of the controlled counter.
- limit  in  CNT_W  terminal value; static while in RUN.
- cnt_en  out  1  one-cycle step strobe to the counter.
- cnt_clr  out  1  one-cycle synchronous clear strobe to the counter.
- state  out  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE.
- done  out  1  high while state==DONE.

Behaviour:
- Reset (async, rst_n low): state=IDLE, cnt_en=0, cnt_clr=0, done=0.
  - Synchronizer flops reset to 1 (released key).
  - Debounce counters reset to 0.
- Key path, per key: 2-flop synchronizer, then debouncer.
  - Debounced level updates only after the synchronized input differs from it for DB_CYC consecutive cycles.
  - Any bounce restarts the count.
  - Press event = 1-cycle pulse on the debounced 1->0 edge. Release generates nothing.
  - Latency from a clean press edge to the event: 2 + DB_CYC cycles.
- All outputs are registered.
  - Event or tick at edge N produces the output effect at edge N+1.
- FSM transitions, evaluated each cycle in priority order:
  1. clr_evt in any state -> IDLE; cnt_clr=1 for one cycle; start_evt that cycle is dropped.
  2. IDLE: start_evt -> RUN.
  3. RUN:
     - start_evt -> PAUSE; a tick in the same cycle is dropped (no cnt_en).
     - Else if cnt_val==limit -> DONE; no cnt_en.
     - Else tick -> cnt_en=1 next cycle.
  4. PAUSE: start_evt -> RUN; ticks ignored.
  5. DONE: start_evt ignored; ticks ignored (see optional feature).
- cnt_en is high only for ticks sampled in RUN. It never coincides with cnt_clr.
- Limit compare is unsigned equality, not >=. If cnt_val jumps past limit, the counter keeps running and wraps; that is the counter's concern.
- limit==0 with cnt_val==0: start from IDLE -> RUN for exactly 1 cycle -> DONE, with zero cnt_en.
- cnt_val reflects cnt_en with one-cycle latency in the counter. The limit check therefore sees the post-increment value one cycle later.
  - The tick interval (>=2 cycles) guarantees no overshoot.
  - Back-to-back ticks are unsupported.
- Reset asserted mid-RUN: immediate IDLE; no cnt_clr is issued. The counter has its own reset.

Optional Feature:
- Macro: COUNTER_RUN_CTRL_AUTO_RELOAD_EN.
- Defined: in DONE, the next tick issues cnt_clr=1 (one cycle), sets done=0 and returns to RUN, giving a periodic counter. clr_evt still forces IDLE.
- Undefined: DONE holds until clr_evt or reset.

Decomposition:
- Shared package holds:
  - The state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_DONE=2'd3, reused by display logic.
  - The 50 MHz clock constant.
- One sub-module, key_debounce (params DB_CYC, DB_W; ports clk, rst_n, key_n, press).
  - Contains the synchronizer, the debounce counter and the edge pulse.
  - Instantiated twice.
- FSM and strobe logic live in counter_run_ctrl.

Test Plan (DB_CYC=4, DB_W=3, CNT_W=8, tick every 10 cycles):
- Reset then release -> state=0, cnt_en=cnt_clr=done=0. Bounce key_start_n low/high/low with 1-cycle glitches, then hold low 6 cycles -> exactly one start event, state=1 at 2+4+1 cycles after the final edge.
- RUN, limit=3, counter model increments on cnt_en from 0 -> three cnt_en pulses, each 1 cycle after its tick. State=3 and done=1 when cnt_val==3; subsequent ticks give no cnt_en.
- RUN, start press whose event lands in the same cycle as a tick -> state=2, no cnt_en. Next start -> state=1; the next tick yields cnt_en.
- Clear and start events in the same cycle from PAUSE -> state=0, one cnt_clr pulse, no RUN.
- limit=0, cnt_val=0, start from IDLE -> state=1 for 1 cycle then 3, zero cnt_en. With COUNTER_RUN_CTRL_AUTO_RELOAD_EN: next tick -> cnt_clr=1, state=1.
- rst_n pulsed low mid-RUN asynchronously, between clock edges -> outputs to reset values immediately, state=0, no cnt_clr.
